// File: rtl/keypad_scan4x4.sv
// rtl/keypad_scan4x4.sv - 4x4 matrix keypad scanner with debounce, valid/ack key handshake and 8-key shift-in word
module keypad_scan4x4 #(
  parameter int SCAN_DIV_BITS = 15,
  parameter int DEBOUNCE_CNT  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  keyRow,
  output logic [3:0]  keyCol,
  input  logic        keyAck,
  output logic        keyValid,
  output logic [3:0]  keyCode,
  output logic        keyOverrun,
  output logic [31:0] dataWord
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [SCAN_DIV_BITS-1:0] CNT_ONE = 1;
  localparam logic [3:0]               DB_LAST = 4'(DEBOUNCE_CNT - 1);

  state_t                   state, state_n;
  logic [SCAN_DIV_BITS-1:0] cnt;
  logic                     tick;
  logic [3:0]               row_meta, row_sync;
  logic [3:0]               row_low;
  logic                     any_low;
  logic [1:0]               low_idx;
  logic [1:0]               col_idx, col_idx_n;
  logic [1:0]               key_row, key_row_n;
  logic [3:0]               db_cnt, db_cnt_n;
  logic                     accept;
  logic                     acked;

  assign tick    = &cnt;
  assign row_low = ~row_sync;
  assign any_low = |row_low;
  assign acked   = keyValid & keyAck;

  // Lowest-index low row wins when several keys share the driven column.
  always_comb begin
    low_idx = 2'd3;
    if (row_low[0])      low_idx = 2'd0;
    else if (row_low[1]) low_idx = 2'd1;
    else if (row_low[2]) low_idx = 2'd2;
  end

  always_comb begin
    state_n   = state;
    col_idx_n = col_idx;
    key_row_n = key_row;
    db_cnt_n  = db_cnt;
    accept    = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (!any_low) begin
            col_idx_n = col_idx + 2'd1;
          end else begin
            key_row_n = low_idx;
            db_cnt_n  = 4'd1;
            state_n   = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (row_low[key_row]) begin
            if (db_cnt == DB_LAST) begin
              accept   = 1'b1;
              db_cnt_n = 4'd0;
              state_n  = HELD;
            end else begin
              db_cnt_n = db_cnt + 4'd1;
            end
          end else begin
            db_cnt_n  = 4'd0;
            col_idx_n = col_idx + 2'd1;
            state_n   = SCAN;
          end
        end
        HELD: begin
          // Counts consecutive all-released ticks; any low row restarts the count.
          if (any_low) begin
            db_cnt_n = 4'd0;
          end else if (db_cnt == DB_LAST) begin
            db_cnt_n  = 4'd0;
            col_idx_n = col_idx + 2'd1;
            state_n   = SCAN;
          end else begin
            db_cnt_n = db_cnt + 4'd1;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= SCAN;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      row_meta   <= 4'hF;
      row_sync   <= 4'hF;
      cnt        <= '0;
      col_idx    <= 2'd0;
      key_row    <= 2'd0;
      db_cnt     <= 4'd0;
      keyCol     <= 4'b1110;
      keyValid   <= 1'b0;
      keyCode    <= 4'd0;
      keyOverrun <= 1'b0;
      dataWord   <= 32'd0;
    end else begin
      row_meta   <= keyRow;
      row_sync   <= row_meta;
      cnt        <= cnt + CNT_ONE;
      col_idx    <= col_idx_n;
      key_row    <= key_row_n;
      db_cnt     <= db_cnt_n;
      keyCol     <= ~(4'b0001 << col_idx_n);
      // A fresh accept outranks an ack landing in the same cycle.
      keyValid   <= accept | (keyValid & ~keyAck);
      keyOverrun <= (keyOverrun & ~acked) | (accept & keyValid & ~keyAck);
      if (accept) begin
        keyCode  <= {key_row, col_idx};
        dataWord <= {dataWord[27:0], key_row, col_idx};
      end
    end
  end

endmodule
